// File: rtl/alu_acc_pkg.sv
// -----------------------------------------------------------------------------
// alu_acc_pkg
// Shared types for the accumulator ALU: operation encoding, control states
// and the bit positions of the {c, v, z, n} flag vector.
// -----------------------------------------------------------------------------
package alu_acc_pkg;

    typedef enum logic [2:0] {
        OP_ADD   = 3'd0,
        OP_OR    = 3'd1,
        OP_AND   = 3'd2,
        OP_XOR   = 3'd3,
        OP_LSR   = 3'd4,
        OP_ASR   = 3'd5,
        OP_LSL   = 3'd6,
        OP_PASSB = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    // Flag vector layout: flags = {c, v, z, n}
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    // Shift operations run through the iterative shifter; all others
    // complete in the combinational core.
    function automatic logic is_shift_op(input op_e op);
        return (op == OP_LSR) || (op == OP_ASR) || (op == OP_LSL);
    endfunction

endpackage

// File: rtl/alu_acc_if.sv
// -----------------------------------------------------------------------------
// alu_acc_if
// Command / result bus of the accumulator ALU.
//   master : command producer and result consumer (drives in_valid, op, a, b,
//            cin, b_inv, use_acc, out_ready)
//   slave  : the ALU (drives in_ready, out_valid, result, flags)
// -----------------------------------------------------------------------------
interface alu_acc_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             b_inv;
    logic             use_acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, op, a, b, cin, b_inv, use_acc, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, op, a, b, cin, b_inv, use_acc, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_acc_core.sv
// -----------------------------------------------------------------------------
// alu_acc_core
// Combinational single-cycle datapath: ADD, OR, AND, XOR and PASSB with the
// carry and signed-overflow flags. Shift opcodes are handled elsewhere; for
// them the outputs are don't-care (PASSB value, c=v=0).
// Ports:
//   i_op      operation code
//   i_a, i_b  operands (i_a already has the accumulator substitution applied)
//   i_cin     carry-in for ADD
//   i_b_inv   invert i_b before ADD / logic / PASSB
//   o_result  WIDTH-bit result
//   o_c, o_v  carry-out and signed overflow
// -----------------------------------------------------------------------------
module alu_acc_core
    import alu_acc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  op_e              i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    input  logic             i_b_inv,
    output logic [WIDTH-1:0] o_result,
    output logic             o_c,
    output logic             o_v
);

    logic [WIDTH-1:0] w_bx;
    logic [WIDTH:0]   w_sum;

    assign w_bx  = i_b ^ {WIDTH{i_b_inv}};
    assign w_sum = {1'b0, i_a} + {1'b0, w_bx} + {{WIDTH{1'b0}}, i_cin};

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a value unassigned, which would infer a latch.
    always_comb begin
        o_result = w_bx;
        o_c      = 1'b0;
        o_v      = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_c      = w_sum[WIDTH];
                // Overflow: both addends share a sign the sum does not have.
                o_v      = (i_a[WIDTH-1] == w_bx[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_OR:   o_result = i_a | w_bx;
            OP_AND:  o_result = i_a & w_bx;
            OP_XOR:  o_result = i_a ^ w_bx;
            default: o_result = w_bx;
        endcase
    end

endmodule

// File: rtl/alu_acc_seq.sv
// -----------------------------------------------------------------------------
// alu_acc_seq
// Accumulator ALU with valid/ready command and result handshakes.
// Non-shift ops complete one cycle after accept; shifts move one bit per
// cycle (latency 1+k). The result is held until the consumer takes it, and a
// new command may be accepted in that same cycle with no bubble.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  alu_acc_if.slave: in_valid/in_ready command handshake with op, a, b,
//        cin, b_inv, use_acc; out_valid/out_ready result handshake with
//        registered result and flags {c, v, z, n}
// -----------------------------------------------------------------------------
module alu_acc_seq
    import alu_acc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH) + 1
) (
    input  logic     clk,
    input  logic     rst,
    alu_acc_if.slave bus
);

    localparam logic [SHW-1:0] K_MAX = SHW'(WIDTH);
    localparam logic [SHW-1:0] K_ONE = SHW'(1);

    // Control
    state_e           r_state;
    state_e           w_state_next;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_last_shift;

    // Command decode
    op_e              w_op;
    logic [WIDTH-1:0] w_opa;
    logic [SHW-1:0]   w_k_raw;
    logic [SHW-1:0]   w_k;
    logic             w_is_shift_op;
    logic             w_shift_cmd;

    // Core outputs
    logic [WIDTH-1:0] w_core_result;
    logic             w_core_c;
    logic             w_core_v;

    // Shifter
    op_e              r_sh_op;
    logic [WIDTH-1:0] r_sh_val;
    logic [SHW-1:0]   r_sh_cnt;
    logic [WIDTH-1:0] w_sh_next;
    logic             w_sh_cout;

    // Result path
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_result;
    logic [3:0]       r_flags;
    logic [WIDTH-1:0] w_res_d;
    logic             w_c_d;
    logic             w_v_d;
    logic [3:0]       w_flags_d;
    logic             w_res_load;

    // -------------------------------------------------------------------------
    // Command decode. The accumulator already holds the value loaded on entry
    // to HOLD, so a use_acc command accepted while leaving HOLD sees it.
    // -------------------------------------------------------------------------
    assign w_op          = op_e'(bus.op);
    assign w_opa         = bus.use_acc ? r_acc : bus.a;
    assign w_k_raw       = bus.b[SHW-1:0];
    assign w_k           = (w_k_raw > K_MAX) ? K_MAX : w_k_raw;
    assign w_is_shift_op = is_shift_op(w_op);
    assign w_shift_cmd   = w_is_shift_op && (w_k != '0);
    assign w_last_shift  = (r_state == ST_SHIFT) && (r_sh_cnt == K_ONE);

    alu_acc_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_op     (w_op),
        .i_a      (w_opa),
        .i_b      (bus.b),
        .i_cin    (bus.cin),
        .i_b_inv  (bus.b_inv),
        .o_result (w_core_result),
        .o_c      (w_core_c),
        .o_v      (w_core_v)
    );

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
            end
            ST_SHIFT: begin
                if (w_last_shift) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_in_ready   = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // No command may be taken while reset is asserted.
        if (rst) begin
            w_in_ready = 1'b0;
        end

        w_accept = bus.in_valid && w_in_ready;
        if (w_accept) begin
            w_state_next = w_shift_cmd ? ST_SHIFT : ST_HOLD;
        end
    end

    // -------------------------------------------------------------------------
    // One-bit shifter step on the working register
    // -------------------------------------------------------------------------
    always_comb begin
        w_sh_next = r_sh_val;
        w_sh_cout = 1'b0;
        case (r_sh_op)
            OP_LSR: begin
                w_sh_next = {1'b0, r_sh_val[WIDTH-1:1]};
                w_sh_cout = r_sh_val[0];
            end
            OP_ASR: begin
                w_sh_next = {r_sh_val[WIDTH-1], r_sh_val[WIDTH-1:1]};
                w_sh_cout = r_sh_val[0];
            end
            OP_LSL: begin
                w_sh_next = {r_sh_val[WIDTH-2:0], 1'b0};
                w_sh_cout = r_sh_val[WIDTH-1];
            end
            default: begin
                w_sh_next = r_sh_val;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Next result selection. A result is loaded either at accept (single-cycle
    // ops and zero-length shifts) or on the final shift step; the two never
    // coincide because no command is accepted during SHIFT.
    // -------------------------------------------------------------------------
    always_comb begin
        w_res_d    = w_core_result;
        w_c_d      = w_core_c;
        w_v_d      = w_core_v;
        w_res_load = 1'b0;
        if (w_last_shift) begin
            w_res_d    = w_sh_next;
            w_c_d      = w_sh_cout;
            w_v_d      = 1'b0;
            w_res_load = 1'b1;
        end else if (w_accept && !w_shift_cmd) begin
            w_res_load = 1'b1;
            if (w_is_shift_op) begin
                w_res_d = w_opa;
                w_c_d   = 1'b0;
                w_v_d   = 1'b0;
            end
        end
    end

    always_comb begin
        w_flags_d         = '0;
        w_flags_d[FLAG_C] = w_c_d;
        w_flags_d[FLAG_V] = w_v_d;
        w_flags_d[FLAG_Z] = (w_res_d == '0);
        w_flags_d[FLAG_N] = w_res_d[WIDTH-1];
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    // NOTE: the shifter working registers are reset along with the visible
    // state; they are few, and it keeps the block fully deterministic after a
    // reset that aborts a shift.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc    <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_sh_op  <= OP_ADD;
            r_sh_val <= '0;
            r_sh_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_sh_op  <= w_op;
                r_sh_val <= w_opa;
                r_sh_cnt <= w_k;
            end else if (r_state == ST_SHIFT) begin
                r_sh_val <= w_sh_next;
                r_sh_cnt <= r_sh_cnt - K_ONE;
            end

            if (w_res_load) begin
                r_result <= w_res_d;
                r_flags  <= w_flags_d;
                r_acc    <= w_res_d;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_result;
    assign bus.flags     = r_flags;

endmodule

// File: tb/tb_alu_acc_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_acc_seq
// Self-checking bench for alu_acc_seq at WIDTH=8: directed vector table,
// hand-written handshake/reset sequences, and randomized commands compared
// against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_alu_acc_seq;

    localparam int W   = 8;
    localparam int MAX_LAT = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    alu_acc_if #(.WIDTH(W)) bus ();

    alu_acc_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] acc_model = 8'h00;

    typedef struct {
        int         op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       binv;
        logic       uacc;
        logic [7:0] exp_res;
        logic [3:0] exp_fl;
        int         exp_lat;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: computes the architectural answer with plain integer
    // arithmetic on 8-bit values.
    function automatic void ref_model(input int op, input logic [7:0] x, input logic [7:0] b,
                                      input logic cin, input logic binv,
                                      output logic [7:0] res, output logic [3:0] fl,
                                      output int lat);
        int xi, bx, k, full, sa, sb, s, sx, r;
        logic c, v;
        xi = int'(x);
        bx = binv ? (255 - int'(b)) : int'(b);
        k  = int'(b) % 16;
        if (k > 8) k = 8;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        lat = 1;
        case (op)
            0: begin
                full = xi + bx + int'(cin);
                r    = full % 256;
                c    = (full >= 256);
                sa   = (xi >= 128) ? xi - 256 : xi;
                sb   = (bx >= 128) ? bx - 256 : bx;
                s    = sa + sb + int'(cin);
                v    = (s > 127) || (s < -128);
            end
            1: r = xi | bx;
            2: r = xi & bx;
            3: r = xi ^ bx;
            4: begin
                r   = xi >> k;
                c   = (k > 0) ? ((xi >> (k - 1)) & 1) != 0 : 1'b0;
                lat = 1 + k;
            end
            5: begin
                sx  = (xi >= 128) ? xi - 256 : xi;
                r   = (sx >>> k) & 255;
                c   = (k > 0) ? ((sx >>> (k - 1)) & 1) != 0 : 1'b0;
                lat = 1 + k;
            end
            6: begin
                full = xi << k;
                r    = full & 255;
                c    = (k > 0) ? ((full >> 8) & 1) != 0 : 1'b0;
                lat  = 1 + k;
            end
            default: r = bx;
        endcase
        res = 8'(r);
        fl  = {c, v, (r == 0), (r >= 128)};
    endfunction

    // Issue one command from IDLE, wait for out_valid, capture, then release.
    task automatic run_cmd(input int op, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic binv, input logic uacc,
                           output logic [7:0] res, output logic [3:0] fl,
                           output int lat, output logic rdy_seen);
        bus.op        = 3'(op);
        bus.a         = a;
        bus.b         = b;
        bus.cin       = cin;
        bus.b_inv     = binv;
        bus.use_acc   = uacc;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        lat      = 1;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < MAX_LAT) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            tick();
            lat++;
        end
        res = bus.result;
        fl  = bus.flags;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] res, exp_res;
        logic [3:0] fl, exp_fl;
        int lat, exp_lat;
        logic rdy_seen, ov_seen;

        vecs[0]  = '{0, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 8'h80, 4'h5, 1};
        vecs[1]  = '{0, 8'h05, 8'h05, 1'b1, 1'b1, 1'b0, 8'h00, 4'hA, 1};
        vecs[2]  = '{5, 8'h90, 8'h03, 1'b0, 1'b0, 1'b0, 8'hF2, 4'h1, 4};
        vecs[3]  = '{4, 8'h81, 8'h08, 1'b0, 1'b0, 1'b0, 8'h00, 4'hA, 9};
        vecs[4]  = '{6, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 4'h0, 1};
        vecs[5]  = '{6, 8'h81, 8'h01, 1'b0, 1'b0, 1'b0, 8'h02, 4'h8, 2};
        vecs[6]  = '{5, 8'h80, 8'h0F, 1'b0, 1'b0, 1'b0, 8'hFF, 4'h9, 9};
        vecs[7]  = '{4, 8'hF0, 8'h14, 1'b0, 1'b0, 1'b0, 8'h0F, 4'h0, 5};
        vecs[8]  = '{1, 8'h30, 8'hF0, 1'b0, 1'b1, 1'b0, 8'h3F, 4'h0, 1};
        vecs[9]  = '{2, 8'hCC, 8'hAA, 1'b0, 1'b0, 1'b0, 8'h88, 4'h1, 1};
        vecs[10] = '{3, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00, 4'h2, 1};
        vecs[11] = '{7, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0, 8'hC3, 4'h1, 1};
        vecs[12] = '{0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 4'hA, 1};
        vecs[13] = '{0, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0, 8'h00, 4'hE, 1};
        vecs[14] = '{6, 8'h03, 8'h02, 1'b1, 1'b1, 1'b0, 8'h0C, 4'h0, 3};
        vecs[15] = '{0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1, 8'h0D, 4'h0, 1};

        bus.in_valid  = 1'b0;
        bus.op        = 3'd0;
        bus.a         = 8'h00;
        bus.b         = 8'h00;
        bus.cin       = 1'b0;
        bus.b_inv     = 1'b0;
        bus.use_acc   = 1'b0;
        bus.out_ready = 1'b0;

        // ---------------- Reset state ----------------
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", 32'(bus.in_ready), 32'd0);
        check("rst out_valid", 32'(bus.out_valid), 32'd0);
        check("rst result", 32'(bus.result), 32'd0);
        check("rst flags", 32'(bus.flags), 32'd0);
        rst = 1'b0;
        #1;
        check("post-rst in_ready", 32'(bus.in_ready), 32'd1);
        acc_model = 8'h00;

        // ---------------- Directed vector table ----------------
        for (int i = 0; i < 16; i++) begin
            run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].binv,
                    vecs[i].uacc, res, fl, lat, rdy_seen);
            check($sformatf("vec%0d result", i), 32'(res), 32'(vecs[i].exp_res));
            check($sformatf("vec%0d flags", i), 32'(fl), 32'(vecs[i].exp_fl));
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d in_ready during shift", i), 32'(rdy_seen), 32'd0);
            acc_model = vecs[i].exp_res;
        end

        // ---------------- Back-to-back with out_ready held ----------------
        bus.out_ready = 1'b1;
        bus.op        = 3'd0;
        bus.a         = 8'h01;
        bus.b         = 8'h01;
        bus.cin       = 1'b0;
        bus.b_inv     = 1'b0;
        bus.use_acc   = 1'b0;
        bus.in_valid  = 1'b1;
        tick();
        check("b2b first out_valid", 32'(bus.out_valid), 32'd1);
        check("b2b first result", 32'(bus.result), 32'h02);
        bus.a       = 8'hEE;
        bus.b       = 8'h03;
        bus.use_acc = 1'b1;
        #1;
        check("b2b in_ready in HOLD", 32'(bus.in_ready), 32'd1);
        tick();
        check("b2b second out_valid", 32'(bus.out_valid), 32'd1);
        check("b2b second result", 32'(bus.result), 32'h05);
        check("b2b second flags", 32'(bus.flags), 32'h0);
        bus.in_valid = 1'b0;
        tick();
        check("b2b drained out_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        acc_model = 8'h05;

        // ---------------- Backpressure in HOLD ----------------
        bus.op       = 3'd3;
        bus.a        = 8'hA5;
        bus.b        = 8'hFF;
        bus.use_acc  = 1'b0;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        check("bp out_valid", 32'(bus.out_valid), 32'd1);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp%0d result", c), 32'(bus.result), 32'h5A);
            check($sformatf("bp%0d flags", c), 32'(bus.flags), 32'h0);
            check($sformatf("bp%0d in_ready", c), 32'(bus.in_ready), 32'd0);
            check($sformatf("bp%0d out_valid", c), 32'(bus.out_valid), 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.out_ready = 1'b0;
        check("bp released out_valid", 32'(bus.out_valid), 32'd0);
        acc_model = 8'h5A;

        // ---------------- Reset during LSL b=8 ----------------
        bus.op       = 3'd6;
        bus.a        = 8'h55;
        bus.b        = 8'h08;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("mid-shift rst out_valid", 32'(bus.out_valid), 32'd0);
        check("mid-shift rst result", 32'(bus.result), 32'd0);
        tick();
        rst = 1'b0;
        ov_seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.out_valid) ov_seen = 1'b1;
        end
        check("aborted shift out_valid", 32'(ov_seen), 32'd0);
        acc_model = 8'h00;
        run_cmd(0, 8'h77, 8'h00, 1'b0, 1'b0, 1'b1, res, fl, lat, rdy_seen);
        check("acc after rst result", 32'(res), 32'h00);
        check("acc after rst flags", 32'(fl), 32'h2);

        // ---------------- Randomized commands vs model ----------------
        for (int n = 0; n < 200; n++) begin
            int op;
            logic [7:0] a, b, x;
            logic cin, binv, uacc;
            op   = int'($urandom_range(0, 7));
            a    = 8'($urandom);
            b    = 8'($urandom);
            cin  = 1'($urandom);
            binv = 1'($urandom);
            uacc = 1'($urandom);
            x    = uacc ? acc_model : a;
            ref_model(op, x, b, cin, binv, exp_res, exp_fl, exp_lat);
            run_cmd(op, a, b, cin, binv, uacc, res, fl, lat, rdy_seen);
            check($sformatf("rnd%0d op%0d result", n, op), 32'(res), 32'(exp_res));
            check($sformatf("rnd%0d op%0d flags", n, op), 32'(fl), 32'(exp_fl));
            check($sformatf("rnd%0d op%0d latency", n, op), 32'(lat), 32'(exp_lat));
            acc_model = exp_res;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
